// File: rtl/ascii_sched_pkg.sv
// Shared types and constants for the ascii_case_sched scheduler and its converter.
package ascii_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } state_e;

  localparam logic [7:0]  ASCII_LC_LO = 8'h61;
  localparam logic [7:0]  ASCII_LC_HI = 8'h7A;
  localparam int unsigned CASE_BIT    = 5;

endpackage

// File: rtl/ascii_case_sched_case_conv.sv
// Combinational ASCII lower-to-upper converter; bytes outside 'a'..'z' pass through.
module case_conv
  import ascii_sched_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       changed_o
);

  always_comb begin
    changed_o = (data_i >= ASCII_LC_LO) && (data_i <= ASCII_LC_HI);
    data_o    = data_i;
    if (changed_o) begin
      data_o[CASE_BIT] = 1'b0;
    end
  end

endmodule

// File: rtl/ascii_case_sched.sv
// Round-robin two-requester scheduler sharing one case_conv, valid/ready output.
// Optional per-requester changed-byte counters: define ASCII_CASE_SCHED_STATS_EN.
module ascii_case_sched
  import ascii_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_src,
  output logic             out_changed,
  output logic             busy
`ifdef ASCII_CASE_SCHED_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  state_e     state_q;
  logic       prio_q;
  logic [7:0] cap_data_q;
  logic       cap_src_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_src_q;
  logic       out_changed_q;

  logic       win;
  logic       xfer;
  logic [7:0] conv_data;
  logic       conv_changed;

  // A lone valid requester wins outright; prio only breaks ties.
  always_comb begin
    win       = (req_valid == 2'b11) ? prio_q : req_valid[1];
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && (|req_valid)) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
    xfer = |req_ready;
  end

  case_conv u_conv (
    .data_i    (cap_data_q),
    .data_o    (conv_data),
    .changed_o (conv_changed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      cap_data_q    <= '0;
      cap_src_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= 1'b0;
      out_changed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            cap_data_q <= win ? req_data1 : req_data0;
            cap_src_q  <= win;
            prio_q     <= ~win;
            state_q    <= CONV;
          end
        end
        CONV: begin
          out_data_q    <= conv_data;
          out_changed_q <= conv_changed;
          out_src_q     <= cap_src_q;
          out_valid_q   <= 1'b1;
          state_q       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign out_changed = out_changed_q;
  assign busy        = (state_q != IDLE);

`ifdef ASCII_CASE_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stats_clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if ((state_q == CONV) && conv_changed) begin
      if (cap_src_q) begin
        if (cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        if (cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
